inv_park_mac: RTL and testbench
===============================

# inv_park_mac

Inverse Park transform stage of the FOC datapath, directly downstream of the sine/cosine table lookup. Takes the d/q voltage commands plus the sin/cos of the electrical angle and produces the stationary-frame alpha/beta voltages for the SVPWM stage. Uses one time-shared signed multiplier sequenced by a small FSM. Input and output use valid/ready handshakes.

## Interface
- N, 16: width of every data port; all values are two's complement.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- vd  input  N  d-axis command, integer scale.
- vq  input  N  q-axis command, integer scale.
- sin_val  input  N  sine, Q1.(N-1).
- cos_val  input  N  cosine, Q1.(N-1).
- in_valid  input  1  input operands valid.
- in_ready  output  1  block can accept operands.
- v_alpha  output  N  alpha voltage = vd·cos − vq·sin.
- v_beta  output  N  beta voltage = vd·sin + vq·cos.
- out_valid  output  1  v_alpha/v_beta valid.
- out_ready  input  1  consumer accepts result.

## Operation
- FSM states: IDLE, MA1, MA2, MB1, MB2, OUT.
- IDLE: in_ready=1. On in_valid=1, capture vd, vq, sin_val, cos_val into internal registers and go to MA1. Otherwise stay.
- MA1: acc ← vd·cos. Next state: MA2.
- MA2: v_alpha register ← fmt(acc − vq·sin). Next state: MB1.
- MB1: acc ← vd·sin. Next state: MB2.
- MB2: v_beta register ← fmt(acc + vq·cos). Next state: OUT.
- OUT: out_valid=1. On out_ready=1, go to IDLE. Otherwise hold state and outputs stable.
- One N×N signed multiplier with a 2N-bit product. The accumulator is 2N+1 bits, so the sum or difference never overflows.
- fmt(x): add 2^(N−2), then arithmetic right shift by N−1 (round half up), then reduce to N bits. The reduction is configurable; see Configuration.
- in_ready is high only in IDLE. The input port ignores in_valid in every other state.
- v_alpha and v_beta hold their last values until the next MA2 or MB2 write. They are meaningful only while out_valid=1.
- Captured operands are used throughout the operation. Input ports may change after the accept cycle.

## Timing
- Reset (rst=1 at a clock edge): state ← IDLE; in_ready=1; out_valid=0; v_alpha=0; v_beta=0; acc=0. Any operation in flight is discarded with no output.
- Accept happens at edge E0 (IDLE with in_valid=1). out_valid rises after edge E0+4, giving a latency of 4 cycles.
- Result handshake completes at the edge where out_valid=1 and out_ready=1. in_ready=1 from the following cycle.
- Best throughput is one result per 6 cycles, with out_ready held at 1.
- If rst=1 and any handshake occur at the same edge, reset wins.
- out_ready is ignored outside OUT.

## Configuration
- INV_PARK_SAT_EN defined: the N-bit reduction saturates. Results above 2^(N−1)−1 clamp to 2^(N−1)−1; results below −2^(N−1) clamp to −2^(N−1).
- INV_PARK_SAT_EN undefined: the N-bit reduction keeps the low N bits, so results wrap modulo 2^N.
- No other behaviour depends on the macro.

## Test plan
- Identity angle: reset, then sin=0, cos=0x7FFF, vd=1000, vq=0 with in_valid pulsed → out_valid exactly 4 cycles after accept, v_alpha=1000, v_beta=0.
- Quarter turn: sin=0x7FFF, cos=0, vd=0, vq=500 → v_alpha=−500 (0xFE0C), v_beta=0.
- Overflow: vd=vq=sin=cos=0x7FFF → v_alpha=0. v_beta=0x7FFF with INV_PARK_SAT_EN; v_beta=0xFFFC (−4) without.
- Negative corner: vd=0x8000, sin=0x8000, cos=0, vq=0 → v_alpha=0. v_beta=0x7FFF with INV_PARK_SAT_EN; v_beta=0x8000 without.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises → outputs stable, in_ready=0, a second in_valid is not accepted. Release out_ready → handshake, then in_ready=1 next cycle and the second operand set is accepted.
- Reset mid-op: assert rst during MB1 → next cycle out_valid=0, outputs 0, in_ready=1. A fresh operation then completes correctly.

Source files
------------

// File: rtl/inv_park_mac.sv
// Inverse Park transform: alpha/beta from d/q commands and sin/cos, one shared multiplier.
// Optional macro INV_PARK_SAT_EN selects a saturating N-bit output reduction instead of wrapping.
module inv_park_mac #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] vd,
  input  logic [N-1:0] vq,
  input  logic [N-1:0] sin_val,
  input  logic [N-1:0] cos_val,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] v_alpha,
  output logic [N-1:0] v_beta,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int ACC_W = 2*N + 1;
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1) <<< (N-2);

  typedef enum logic [2:0] {IDLE, MA1, MA2, MB1, MB2, OUT} state_t;

  state_t state, state_next;

  logic signed [N-1:0]     vd_r, vq_r, sin_r, cos_r;
  logic signed [N-1:0]     mul_a, mul_b;
  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;

  // Round half up, drop the Q1.(N-1) fraction, then reduce to N bits.
  function automatic logic [N-1:0] fmt(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] s;
    logic [N-1:0] res;
    s = (x + ROUND) >>> (N-1);
`ifdef INV_PARK_SAT_EN
    if (s[ACC_W-1] && !(&s[ACC_W-2:N-1]))
      res = {1'b1, {(N-1){1'b0}}};
    else if (!s[ACC_W-1] && (|s[ACC_W-2:N-1]))
      res = {1'b0, {(N-1){1'b1}}};
    else
      res = s[N-1:0];
`else
    res = s[N-1:0];
`endif
    return res;
  endfunction

  assign prod     = mul_a * mul_b;
  assign prod_ext = {prod[2*N-1], prod};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mul_a      = vd_r;
    mul_b      = cos_r;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MA1;
      end
      MA1: state_next = MA2;
      MA2: begin
        mul_a      = vq_r;
        mul_b      = sin_r;
        state_next = MB1;
      end
      MB1: begin
        mul_b      = sin_r;
        state_next = MB2;
      end
      MB2: begin
        mul_a      = vq_r;
        state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, accumulator and result registers follow the FSM step.
  always_ff @(posedge clk) begin
    if (rst) begin
      vd_r    <= '0;
      vq_r    <= '0;
      sin_r   <= '0;
      cos_r   <= '0;
      acc     <= '0;
      v_alpha <= '0;
      v_beta  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          vd_r  <= vd;
          vq_r  <= vq;
          sin_r <= sin_val;
          cos_r <= cos_val;
        end
        MA1: acc <= prod_ext;
        MA2: v_alpha <= fmt(acc - prod_ext);
        MB1: acc <= prod_ext;
        MB2: v_beta <= fmt(acc + prod_ext);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_park_mac.sv
// Self-checking bench for inv_park_mac: directed corners, random operands, backpressure, reset.
module tb_inv_park_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] vd, vq, sin_val, cos_val;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] v_alpha, v_beta;
  logic        out_valid;
  logic        out_ready;

  int n_vec = 0;
  int n_err = 0;

  inv_park_mac #(.N(16)) dut (
    .clk(clk), .rst(rst), .vd(vd), .vq(vq), .sin_val(sin_val), .cos_val(cos_val),
    .in_valid(in_valid), .in_ready(in_ready), .v_alpha(v_alpha), .v_beta(v_beta),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference: exact integer products, round half up, then reduce to 16 bits.
  function automatic logic [15:0] ref_fmt(input longint x);
    longint r;
    r = (x + 64'sd16384) >>> 15;
`ifdef INV_PARK_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  function automatic logic [15:0] ref_alpha(input logic [15:0] a, b, s, c);
    longint d, q, sn, cs;
    d = longint'($signed(a)); q = longint'($signed(b));
    sn = longint'($signed(s)); cs = longint'($signed(c));
    return ref_fmt(d*cs - q*sn);
  endfunction

  function automatic logic [15:0] ref_beta(input logic [15:0] a, b, s, c);
    longint d, q, sn, cs;
    d = longint'($signed(a)); q = longint'($signed(b));
    sn = longint'($signed(s)); cs = longint'($signed(c));
    return ref_fmt(d*sn + q*cs);
  endfunction

  task automatic start_op(input logic [15:0] a, b, s, c);
    vd = a; vq = b; sin_val = s; cos_val = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vd = 16'($urandom); vq = 16'($urandom);
    sin_val = 16'($urandom); cos_val = 16'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || v_alpha !== 16'h0 || v_beta !== 16'h0) begin
      n_err++;
      $display("[TB] FAIL reset: in_ready=%b out_valid=%b alpha=%h beta=%h, want 1 0 0000 0000",
               in_ready, out_valid, v_alpha, v_beta);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] t_a[4], t_b[4], t_s[4], t_c[4], e_a[4], e_b[4];
    int lat;
    t_a = '{16'd1000, 16'd0,   16'h7FFF, 16'h8000};
    t_b = '{16'd0,    16'd500, 16'h7FFF, 16'h0000};
    t_s = '{16'h0000, 16'h7FFF, 16'h7FFF, 16'h8000};
    t_c = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000};
`ifdef INV_PARK_SAT_EN
    e_a = '{16'd1000, 16'hFE0C, 16'h0000, 16'h0000};
    e_b = '{16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
`else
    e_a = '{16'd1000, 16'hFE0C, 16'h0000, 16'h0000};
    e_b = '{16'h0000, 16'h0000, 16'hFFFC, 16'h8000};
`endif
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL directed%0d_ready: in_ready=%b want 1", i, in_ready);
      end
      start_op(t_a[i], t_b[i], t_s[i], t_c[i]);
      wait_out(lat);
      n_vec++;
      if (lat !== 4) begin
        n_err++;
        $display("[TB] FAIL directed%0d_latency: got %0d want 4", i, lat);
      end
      n_vec++;
      if (v_alpha !== e_a[i] || v_beta !== e_b[i]) begin
        n_err++;
        $display("[TB] FAIL directed%0d_result: alpha=%h beta=%h want %h %h",
                 i, v_alpha, v_beta, e_a[i], e_b[i]);
      end
      finish_out();
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL directed%0d_handshake: in_ready=%b out_valid=%b want 1 0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, s, c, ea, eb;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom); b = 16'($urandom); s = 16'($urandom); c = 16'($urandom);
      ea = ref_alpha(a, b, s, c);
      eb = ref_beta(a, b, s, c);
      start_op(a, b, s, c);
      wait_out(lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_vec++;
      if (lat !== 4 || v_alpha !== ea || v_beta !== eb) begin
        n_err++;
        $display("[TB] FAIL random%0d: lat=%0d alpha=%h beta=%h want lat=4 %h %h",
                 i, lat, v_alpha, v_beta, ea, eb);
      end
      finish_out();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ha, hb, a2, b2, s2, c2;
    int lat;
    start_op(16'd1234, 16'hFC00, 16'h5A82, 16'h5A82);
    wait_out(lat);
    ha = v_alpha; hb = v_beta;
    a2 = 16'($urandom); b2 = 16'($urandom); s2 = 16'($urandom); c2 = 16'($urandom);
    vd = a2; vq = b2; sin_val = s2; cos_val = c2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || v_alpha !== ha || v_beta !== hb) begin
        n_err++;
        $display("[TB] FAIL backpressure_hold%0d: ov=%b ir=%b alpha=%h beta=%h want 1 0 %h %h",
                 i, out_valid, in_ready, v_alpha, v_beta, ha, hb);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL backpressure_release: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL backpressure_accept: in_ready=%b want 0", in_ready);
    end
    wait_out(lat);
    n_vec++;
    if (lat !== 4 || v_alpha !== ref_alpha(a2, b2, s2, c2) || v_beta !== ref_beta(a2, b2, s2, c2)) begin
      n_err++;
      $display("[TB] FAIL backpressure_second: lat=%0d alpha=%h beta=%h want lat=4 %h %h",
               lat, v_alpha, v_beta, ref_alpha(a2, b2, s2, c2), ref_beta(a2, b2, s2, c2));
    end
    finish_out();
  endtask

  task automatic test_reset_midop();
    int lat;
    start_op(16'd3000, 16'd2000, 16'h4000, 16'h6000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || v_alpha !== 16'h0 || v_beta !== 16'h0) begin
      n_err++;
      $display("[TB] FAIL reset_midop: ov=%b ir=%b alpha=%h beta=%h want 0 1 0000 0000",
               out_valid, in_ready, v_alpha, v_beta);
    end
    start_op(16'hF830, 16'd700, 16'hC000, 16'h6ED9);
    wait_out(lat);
    n_vec++;
    if (lat !== 4 || v_alpha !== ref_alpha(16'hF830, 16'd700, 16'hC000, 16'h6ED9) ||
        v_beta !== ref_beta(16'hF830, 16'd700, 16'hC000, 16'h6ED9)) begin
      n_err++;
      $display("[TB] FAIL reset_fresh_op: lat=%0d alpha=%h beta=%h want lat=4 %h %h",
               lat, v_alpha, v_beta, ref_alpha(16'hF830, 16'd700, 16'hC000, 16'h6ED9),
               ref_beta(16'hF830, 16'd700, 16'hC000, 16'h6ED9));
    end
    finish_out();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    vd = '0; vq = '0; sin_val = '0; cos_val = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
